// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the bit-level stream blocks.
package bitstream_pkg;

  typedef enum logic {IDLE, SHIFT} feeder_state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Width of a down-counter that has to hold DATA_W-1.
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// DATA_W-bit parallel-load shift register. head is the bit currently on offer;
// MSB_FIRST selects which end of the word leaves first.
module ser_shift_reg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              head
);

  logic [DATA_W-1:0] sr_q, sr_d;

  // Load has priority: the last-bit cycle of a gapless stream shifts and reloads at once.
  always_comb begin
    sr_d = sr_q;
    if (load)
      sr_d = din;
    else if (shift)
      sr_d = MSB_FIRST ? {sr_q[DATA_W-2:0], 1'b0} : {1'b0, sr_q[DATA_W-1:1]};
  end

  // Word storage, cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign head = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the bit-level sequence detectors.
// Optional one-entry prefetch buffer for gapless streaming: SERIAL_FEEDER_PREFETCH_EN.
import bitstream_pkg::*;

module serial_bit_feeder #(
  parameter int   DATA_W    = DEFAULT_DATA_W,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = cnt_w(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ser_out_q, ser_out_d;
  logic          ser_valid_q, ser_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          sr_load, sr_shift, head;
  logic [DATA_W-1:0] sr_din;
  logic          xfer;

`ifdef SERIAL_FEEDER_PREFETCH_EN
  logic [DATA_W-1:0] pf_buf_q, pf_buf_d;
  logic              buf_full_q, buf_full_d;
  assign s_ready = !buf_full_q;
`else
  assign s_ready = (state_q == IDLE);
`endif

  assign xfer = s_valid && s_ready;

  // Next-state, counter, shift control and registered serial outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ser_out_d    = IDLE_BIT;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_din       = s_data;
`ifdef SERIAL_FEEDER_PREFETCH_EN
    pf_buf_d     = pf_buf_q;
    buf_full_d   = buf_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          sr_load = 1'b1;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser_out_d   = head;
        ser_valid_d = 1'b1;
        sr_shift    = 1'b1;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          frame_done_d = 1'b1;
`ifdef SERIAL_FEEDER_PREFETCH_EN
          // Buffered word first (s_ready is low then), else bypass a word offered now.
          if (buf_full_q) begin
            sr_load    = 1'b1;
            sr_din     = pf_buf_q;
            buf_full_d = 1'b0;
            cnt_d      = CNT_LAST;
          end else if (xfer) begin
            sr_load = 1'b1;
            cnt_d   = CNT_LAST;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
`ifdef SERIAL_FEEDER_PREFETCH_EN
        else if (xfer) begin
          pf_buf_d   = s_data;
          buf_full_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ser_out_q    <= IDLE_BIT;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SERIAL_FEEDER_PREFETCH_EN
  // Prefetch buffer; contents are meaningless while buf_full_q is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_buf_q   <= '0;
      buf_full_q <= 1'b0;
    end else begin
      pf_buf_q   <= pf_buf_d;
      buf_full_q <= buf_full_d;
    end
  end
`endif

  ser_shift_reg #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk  (clk),
    .reset(reset),
    .load (sr_load),
    .shift(sr_shift),
    .din  (sr_din),
    .head (head)
  );

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: one MSB-first and one LSB-first instance.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data_m, s_data_l;
  logic       s_valid_m, s_valid_l;
  logic       s_ready_m, ser_out_m, ser_valid_m, frame_done_m, busy_m;
  logic       s_ready_l, ser_out_l, ser_valid_l, frame_done_l, busy_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .s_data(s_data_m), .s_valid(s_valid_m), .s_ready(s_ready_m),
    .ser_out(ser_out_m), .ser_valid(ser_valid_m), .frame_done(frame_done_m), .busy(busy_m)
  );

  serial_bit_feeder #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .s_data(s_data_l), .s_valid(s_valid_l), .s_ready(s_ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .frame_done(frame_done_l), .busy(busy_l)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_m;   // bits in send order, first bit at [7]
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offer one word to both instances and check all 8 bits plus the trailing idle cycle.
  task automatic send_check(input logic [7:0] d, input logic [7:0] em, input logic [7:0] el);
    @(negedge clk);
    chk("ready_idle", {s_ready_m, s_ready_l}, 2'b11);
    s_data_m = d; s_data_l = d; s_valid_m = 1'b1; s_valid_l = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid_m = 1'b0; s_valid_l = 1'b0; s_data_m = ~d; s_data_l = ~d;
    chk("latency_no_bit_yet", {ser_valid_m, ser_valid_l}, 2'b00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("bit", {ser_out_m, ser_out_l}, {em[7-k], el[7-k]});
      chk("ser_valid", {ser_valid_m, ser_valid_l}, 2'b11);
      chk("frame_done", {frame_done_m, frame_done_l}, {2{k == 7}});
      chk("busy", {busy_m, busy_l}, {2{k != 7}});
`ifdef SERIAL_FEEDER_PREFETCH_EN
      chk("s_ready", {s_ready_m, s_ready_l}, 2'b11);
`else
      chk("s_ready", {s_ready_m, s_ready_l}, {2{k == 7}});
`endif
    end
    @(negedge clk);
    chk("idle_after", {ser_out_m, ser_valid_m, frame_done_m, ser_out_l, ser_valid_l, frame_done_l}, 6'b0);
  endtask

  logic [7:0] w[3];
  logic sv[64], so[64], sr[64], bz[64];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h01, 8'h01, 8'h80};
    vecs[2] = '{8'h0A, 8'h0A, 8'h50};
    vecs[3] = '{8'h12, 8'h12, 8'h48};
    vecs[4] = '{8'hF0, 8'hF0, 8'h0F};
    vecs[5] = '{8'hC3, 8'hC3, 8'hC3};
    w[0] = 8'h0A; w[1] = 8'hA0; w[2] = 8'h55;

    s_data_m = '0; s_data_l = '0; s_valid_m = 1'b0; s_valid_l = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_reset", {ser_out_m, ser_valid_m, frame_done_m, busy_m}, 4'b0000);
    reset = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_m", {ser_out_m, ser_valid_m, s_ready_m, busy_m, frame_done_m}, 5'b00100);
      chk("idle_l", {ser_out_l, ser_valid_l, s_ready_l, busy_l, frame_done_l}, 5'b00100);
    end

    // Word table, both bit orders.
    for (int i = 0; i < 6; i++)
      send_check(vecs[i].data, vecs[i].exp_m, vecs[i].exp_l);

    // Asynchronous reset during the 4th bit of 8'hFF.
    @(negedge clk);
    s_data_m = 8'hFF; s_valid_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid_m = 1'b0;
    repeat (4) @(negedge clk);
    chk("ff_bit4", {ser_out_m, ser_valid_m, busy_m}, 3'b111);
    #1 reset = 1'b0;
    #1 chk("async_reset", {ser_out_m, ser_valid_m, frame_done_m, busy_m, s_ready_m}, 5'b00001);
    @(negedge clk);
    reset = 1'b1;
    send_check(8'h81, 8'h81, 8'h81);

    // Back-to-back words with s_valid held high on the MSB-first instance.
    begin
      int idx, nw, f, drops, stalls;
      logic xfer;
`ifdef SERIAL_FEEDER_PREFETCH_EN
      nw = 3;
`else
      nw = 2;
`endif
      @(negedge clk);
      idx = 0; s_data_m = w[0]; s_valid_m = 1'b1;
      xfer = s_ready_m;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        sv[c] = ser_valid_m; so[c] = ser_out_m; sr[c] = s_ready_m; bz[c] = busy_m;
        if (xfer) begin
          idx++;
          if (idx >= nw) s_valid_m = 1'b0;
          else           s_data_m  = w[idx];
        end
        xfer = s_valid_m && s_ready_m;
      end
      f = -1;
      for (int c = 63; c >= 0; c--) if (sv[c]) f = c;
      chk("stream_start_found", (f >= 0 && f < 30), 1);
      if (f < 0 || f >= 30) f = 0;
      drops = 0; stalls = 0;
      for (int c = 0; c < 64; c++) begin
        if (!sr[c]) drops++;
        if (bz[c] && sr[c]) stalls++;
      end
`ifdef SERIAL_FEEDER_PREFETCH_EN
      for (int i = 0; i < 24; i++) begin
        chk("gapless_valid", sv[f+i], 1'b1);
        chk("gapless_bit", so[f+i], w[i/8][7-(i%8)]);
      end
      chk("stream_end", sv[f+24], 1'b0);
      chk("ready_dropped", (drops > 0), 1);
      chk("det_1010_boundary", {so[f+6], so[f+7], so[f+8], so[f+9]}, 4'b1010);
`else
      for (int i = 0; i < 8; i++) begin
        chk("w0_valid", sv[f+i], 1'b1);
        chk("w0_bit", so[f+i], w[0][7-i]);
        chk("w1_valid", sv[f+9+i], 1'b1);
        chk("w1_bit", so[f+9+i], w[1][7-i]);
      end
      chk("gap_cycle", {sv[f+8], so[f+8]}, 2'b00);
      chk("stream_end", sv[f+17], 1'b0);
      chk("ready_low_in_shift", stalls, 0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
